// File: rtl/max_search_pkg.sv
// Shared types and constants for the max-search sequencer.
// The state enum and sample width are common to the controller and its bench.
package max_search_pkg;

   localparam int DATA_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      FIRST,
      CAPTURE,
      EVAL,
      DONE
   } state_t;

endpackage

// File: rtl/fourBitGreaterThan.sv
// Unsigned 4-bit magnitude comparator: z=1 when switch[7:4] > switch[3:0].
// Combinational; the sequencer time-shares it across a whole frame.
module fourBitGreaterThan (
   input  logic [7:0] switch,
   output logic       z
);

   logic [3:0] a;
   logic [3:0] b;

   assign a = switch[7:4];
   assign b = switch[3:0];

   // MSB-first priority chain: the first differing bit decides.
   always_comb begin
      z = 1'b0;
      if (a[3] != b[3])      z = a[3];
      else if (a[2] != b[2]) z = a[2];
      else if (a[1] != b[1]) z = a[1];
      else if (a[0] != b[0]) z = a[0];
   end

endmodule

// File: rtl/max_search_sequencer.sv
// Streams COUNT samples through one shared comparator, tracking the running
// maximum and the index of its first occurrence; pulses done when final.
module max_search_sequencer
   import max_search_pkg::*;
#(
   parameter int COUNT = 8,
   localparam int IDX_W = $clog2(COUNT)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] max_val,
   output logic [IDX_W-1:0]  max_idx,
   output logic              led
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

   state_t            state_reg;
   logic [DATA_W-1:0] max_reg;
   logic [DATA_W-1:0] cand_reg;
   logic [IDX_W-1:0]  max_idx_reg;
   logic [IDX_W-1:0]  cand_idx_reg;
   logic [IDX_W-1:0]  cnt_reg;
   logic              in_ready_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              led_reg;
   logic              cand_gt;

   fourBitGreaterThan u_gt (
      .switch ({cand_reg, max_reg}),
      .z      (cand_gt)
   );

   // Outputs are registered alongside the state so they always agree with it.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_reg    <= IDLE;
         max_reg      <= '0;
         cand_reg     <= '0;
         max_idx_reg  <= '0;
         cand_idx_reg <= '0;
         cnt_reg      <= '0;
         in_ready_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         led_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg    <= FIRST;
                  max_reg      <= '0;
                  max_idx_reg  <= '0;
                  led_reg      <= 1'b0;
                  in_ready_reg <= 1'b1;
                  busy_reg     <= 1'b1;
               end
            end
            FIRST: begin
               if (in_valid) begin
                  max_reg     <= in_data;
                  max_idx_reg <= '0;
                  cnt_reg     <= IDX_W'(1);
                  state_reg   <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (in_valid) begin
                  cand_reg     <= in_data;
                  cand_idx_reg <= cnt_reg;
                  in_ready_reg <= 1'b0;
                  state_reg    <= EVAL;
               end
            end
            EVAL: begin
               // Strict compare: equal values never displace the earlier index.
               if (cand_gt) begin
                  max_reg     <= cand_reg;
                  max_idx_reg <= cand_idx_reg;
               end
               if (cnt_reg == LAST_IDX) begin
                  state_reg <= DONE;
               end else begin
                  cnt_reg      <= cnt_reg + IDX_W'(1);
                  in_ready_reg <= 1'b1;
                  state_reg    <= CAPTURE;
               end
            end
            DONE: begin
               done_reg  <= 1'b1;
               led_reg   <= 1'b1;
               busy_reg  <= 1'b0;
               cnt_reg   <= '0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg    <= IDLE;
               in_ready_reg <= 1'b0;
               busy_reg     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = in_ready_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign max_val  = max_reg;
   assign max_idx  = max_idx_reg;
   assign led      = led_reg;

endmodule

// File: tb/tb_max_search_sequencer.sv
// Directed plus randomized frames for max_search_sequencer (COUNT=8), checked
// against a plain first-maximum reference and the 2*COUNT+stall latency rule.
module tb_max_search_sequencer;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       start;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       busy;
   logic       done;
   logic [3:0] max_val;
   logic [2:0] max_idx;
   logic       led;

   int checks = 0;
   int failures = 0;

   max_search_sequencer #(.COUNT(8)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .max_val  (max_val),
      .max_idx  (max_idx),
      .led      (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: maximum of the frame and the first index holding it.
   task automatic model(input logic [3:0] s [8], output logic [3:0] mv, output logic [2:0] mi);
      mv = s[0];
      mi = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (s[i] > mv) begin
            mv = s[i];
            mi = 3'(i);
         end
      end
   endtask

   task automatic run_frame(input logic [3:0] s [8], input int stall_at, input int stall_n,
                            input bit poke_start, input string tag);
      int k;
      int edges;
      int stalls;
      int lat;
      logic [3:0] mv;
      logic [2:0] mi;
      model(s, mv, mi);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      edges = 0;
      k = 0;
      stalls = stall_n;
      lat = -1;
      check({tag, "_clr_led"}, 32'(led), 32'd0);
      check({tag, "_clr_max"}, 32'(max_val), 32'd0);
      check({tag, "_clr_idx"}, 32'(max_idx), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      while (edges < 200) begin
         if (done === 1'b1) begin
            lat = edges;
            break;
         end
         start = 1'b0;
         if (in_ready === 1'b1 && k < 8) begin
            if (k == stall_at && stalls > 0) begin
               in_valid = 1'b0;
               stalls--;
            end else begin
               in_valid = 1'b1;
               in_data = s[k];
               k++;
            end
         end else if (k < 8) begin
            // Junk offered while not ready must never be sampled.
            in_valid = 1'b1;
            in_data = 4'($urandom);
            if (k > 0) start = poke_start;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      check({tag, "_latency"}, 32'(lat), 32'(16 + stall_n));
      check({tag, "_max_val"}, 32'(max_val), 32'(mv));
      check({tag, "_max_idx"}, 32'(max_idx), 32'(mi));
      check({tag, "_led"}, 32'(led), 32'd1);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, "_done_1cyc"}, 32'(done), 32'd0);
      check({tag, "_hold_val"}, 32'(max_val), 32'(mv));
      $display("frame %s: max_val=%0d max_idx=%0d latency=%0d", tag, max_val, max_idx, lat);
   endtask

   initial begin
      logic [3:0] s [8];
      int saw_done;
      n_rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_max", 32'(max_val), 32'd0);
      check("rst_idx", 32'(max_idx), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      n_rst = 1'b1;

      s = '{4'd3, 4'd7, 4'd2, 4'd9, 4'd9, 4'd1, 4'd0, 4'd5};
      run_frame(s, -1, 0, 1'b0, "basic");
      s = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      run_frame(s, -1, 0, 1'b0, "zeros");
      s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
      run_frame(s, -1, 0, 1'b0, "ascend");
      s = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
      run_frame(s, -1, 0, 1'b0, "all15");
      s = '{4'd4, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
      run_frame(s, -1, 0, 1'b0, "tie_idx1");
      s = '{4'd3, 4'd7, 4'd2, 4'd9, 4'd9, 4'd1, 4'd0, 4'd5};
      run_frame(s, 4, 3, 1'b0, "stall3");
      s = '{4'd2, 4'd11, 4'd6, 4'd11, 4'd13, 4'd1, 4'd13, 4'd8};
      run_frame(s, -1, 0, 1'b1, "start_in_eval");

      // Reset asserted while sample 5 is being offered aborts the frame.
      s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd14, 4'd6, 4'd7, 4'd8};
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int k = 0;
         for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
            if (in_ready === 1'b1) begin
               in_valid = 1'b1;
               in_data = s[k];
               k++;
            end else begin
               in_valid = 1'b0;
            end
            @(negedge clk);
         end
         check("abort_reached_s5", 32'(k), 32'd5);
      end
      if (in_ready === 1'b1) begin
         in_valid = 1'b1;
         in_data = s[5];
      end
      n_rst = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_ready", 32'(in_ready), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_max", 32'(max_val), 32'd0);
      check("abort_idx", 32'(max_idx), 32'd0);
      check("abort_led", 32'(led), 32'd0);
      n_rst = 1'b1;
      saw_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0) saw_done++;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      $display("abort: outputs cleared, done pulses after reset=%0d", saw_done);

      s = '{4'd5, 4'd12, 4'd3, 4'd12, 4'd0, 4'd9, 4'd1, 4'd2};
      run_frame(s, -1, 0, 1'b0, "after_abort");

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 8; i++) s[i] = 4'($urandom_range(0, 15));
         run_frame(s, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/max_search_sequencer.md
Name: max_search_sequencer

Overview:
- Sequences a frame of COUNT 4-bit samples through one shared fourBitGreaterThan comparator, one comparison at a time.
- Reports the maximum value and the index where it first occurred.
- Sits between switch/sample input logic and the board LED/display path. It is the controller that drives the comparator's 8-bit operand bus and consumes its single-bit result.

Parameters:
- COUNT, 8, samples per frame; legal range 2..16.
- IDX_W, $clog2(COUNT), width of index outputs; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  synchronous active-low reset.
- start  in  1  begin a new frame; sampled only in IDLE.
- in_valid  in  1  in_data holds a sample.
- in_data  in  4  sample value, unsigned.
- in_ready  out  1  block accepts in_data this cycle.
- busy  out  1  frame in progress (any state except IDLE).
- done  out  1  one-cycle pulse when the result is final.
- max_val  out  4  largest sample of the last completed frame.
- max_idx  out  IDX_W  index (0-based) of the first occurrence of max_val.
- led  out  1  result valid. Set with done, cleared by start or reset.

Behaviour:
- Reset (n_rst low at a clk edge):
  - State goes to IDLE.
  - in_ready=0, busy=0, done=0, max_val=0, max_idx=0, led=0.
  - Sample counter and candidate register are cleared.
  - Reset mid-frame aborts the frame with no done pulse.
- Comparator hookup:
  - switch[7:4] = cand register, switch[3:0] = max register.
  - z=1 means cand > max, strictly unsigned.
- IDLE:
  - in_ready=0.
  - start=1 goes to FIRST; max_val, max_idx and led are cleared to 0 at that edge.
- FIRST:
  - in_ready=1.
  - On in_valid: max←in_data, max_idx←0, cnt←1, go to CAPTURE.
- CAPTURE:
  - in_ready=1.
  - On in_valid: cand←in_data, cand_idx←cnt, go to EVAL.
  - If in_valid=0, stay in CAPTURE (stall).
- EVAL:
  - in_ready=0.
  - If z=1: max←cand, max_idx←cand_idx.
  - If cnt==COUNT-1, go to DONE. Otherwise cnt←cnt+1 and go to CAPTURE.
- DONE:
  - done=1 for exactly one cycle, led←1, go to IDLE.
- Handshake: a transfer occurs on a clk edge where in_valid and in_ready are both 1. in_data is sampled only at that edge.
- Ties: strict compare, so the earliest index wins.
- start while busy is ignored. Only start sampled in IDLE has effect.
- Latency: with in_valid held high, done is high in the cycle 2*COUNT cycles after the edge that sampled start. For COUNT=8 that is 16.
- Results (max_val, max_idx, led) hold from DONE until the next accepted start or reset.
- Counter wrap: cnt never exceeds COUNT-1. IDX_W is sized so COUNT-1 is representable.

Decomposition:
- Package max_search_pkg holds:
  - state enum: IDLE, FIRST, CAPTURE, EVAL, DONE.
  - DATA_W=4 constant.
- Sub-module: the existing fourBitGreaterThan, instantiated once. It is the only comparison logic; no inline ">" on samples.
- All other logic (FSM, counter, registers) is in max_search_sequencer.

Test Plan:
- COUNT=8, in_valid high, samples 3,7,2,9,9,1,0,5 -> done pulse in cycle 16 after start edge, max_val=9, max_idx=3, led=1.
- Samples all 0 -> max_val=0, max_idx=0, led=1. Also samples ascending 0..7 -> max_val=7, max_idx=7.
- Samples 15,15,…,15 -> max_idx=0 (tie keeps first). Also samples 4,15,15,… -> max_idx=1.
- in_valid deasserted for 3 cycles before sample 4 -> in_ready stays 1 in CAPTURE, result unchanged, done delayed by exactly 3 cycles.
- start pulsed again during EVAL -> ignored. After done, new start -> led, max_val, max_idx clear to 0 on the next edge.
- n_rst low during sample 5 of a frame -> the next edge forces all outputs to 0 and state to IDLE, and no done pulse follows. A new frame then completes normally.
